vend_coin_scheduler: RTL
========================

Name: vend_coin_scheduler

Overview:
- Front-end controller for the single-product vending core (price 15 rs, 2-bit coin code: 01 = 5 rs, 10 = 10 rs, 00 = cancel).
- Arbitrates two coin acceptors (front slot A, side slot B) into a small coin FIFO and feeds coins to the core one per enabled cycle.
- Mirrors the core's credit, runs the inactivity timeout, and sequences the dispense motor and change-return handshakes.
- Tracks stock and rejects coins when sold out.

Parameters:
- FIFO_DEPTH, 4, coin FIFO entries (power of 2, >= 2)
- TIMEOUT_CYC, 1000, idle cycles with credit > 0 and FIFO empty before a cancel is issued
- STOCK_W, 6, stock counter width
- INIT_STOCK, 10, stock value loaded at reset

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_a  in  1  slot A coin valid; held until ack_a
- coin_a  in  2  slot A coin code (01 or 10 only)
- ack_a  out  1  one-cycle accept of slot A coin
- req_b, coin_b, ack_b  same for slot B
- coin_reject  out  1  one-cycle pulse: acked coin is to be returned by the mechanism (sold out)
- core_en  out  1  core clock-enable; the core advances only when 1
- core_in  out  2  coin code to core, valid when core_en = 1
- motor_start  out  1  one-cycle pulse, start the dispense motor
- motor_done  in  1  one-cycle pulse, dispense finished
- change_req  out  1  held high until change_done
- change_amt  out  2  01 = 5 rs, 10 = 10 rs, stable while change_req
- change_done  in  1  one-cycle pulse, change paid
- restock  in  1  one-cycle pulse, add restock_qty
- restock_qty  in  STOCK_W  units to add
- stock  out  STOCK_W  current stock
- sold_out  out  1  stock == 0
- busy  out  1  state != IDLE or credit != 0

Behaviour:
- Reset values: all outputs 0 except stock = INIT_STOCK. FIFO empty, credit = 0, state = IDLE, round-robin pointer = A.
- Arbitration:
  - Each cycle at most one requester is acked, round-robin. The pointer flips to the other slot after a grant.
  - Grant only when the FIFO is not full and the state is IDLE or FEED.
  - When sold_out = 1, grants still occur but the coin is not queued; coin_reject pulses in the same cycle as ack.
- FSM states: IDLE, FEED, DISPENSE, CHANGE.
  - IDLE/FEED: when the FIFO is non-empty, pop one coin per cycle. Drive core_en = 1 with core_in = that coin, and update credit. FEED is entered while the FIFO is non-empty; return to IDLE when it is empty.
  - Credit update, price 15:
    - 0 + 5 -> 5; 0 + 10 -> 10; 5 + 5 -> 10.
    - 5 + 10 or 10 + 5 -> vend, no change.
    - 10 + 10 -> vend, change 5.
    - On vend: credit -> 0 and go to DISPENSE.
  - DISPENSE: motor_start pulses on the first cycle. Wait for motor_done, then decrement stock.
    - If change is owed, go to CHANGE; otherwise go to IDLE.
    - No FIFO pops and no acks while in DISPENSE.
  - CHANGE: hold change_req and change_amt until change_done, then go to IDLE. No pops or acks while in CHANGE.
- Timeout:
  - The counter runs only in IDLE with credit != 0 and the FIFO empty. Any pop clears it.
  - At TIMEOUT_CYC - 1: drive core_en = 1 with core_in = 00. Set change_amt = credit, credit = 0, and go to CHANGE.
- Latency: a coin acked in cycle t reaches core_in no earlier than t+1. It is popped in t+1 if the FIFO was empty and the state is IDLE/FEED.
- core_en = 0 in every cycle without a pop or cancel (core holds state). core_in = 00 whenever core_en = 0.
- Stock:
  - Restock adds restock_qty, saturating at 2^STOCK_W - 1.
  - Restock and a dispense decrement in the same cycle apply both: stock + qty - 1, saturated.
  - A vend is never started with stock 0, because coins are rejected while sold_out.
- Sold-out transition with queued coins: coins already in the FIFO are still fed. If the credit left is non-zero, the timeout path refunds it.
- Reset mid-dispense or mid-change aborts immediately. Outputs return to reset values; queued coins are lost (mechanism is responsible).

Decomposition:
- Shared package vend_pkg:
  - coin code constants COIN_NONE = 00, COIN_5 = 01, COIN_10 = 10
  - PRICE_UNITS = 3 (5 rs units)
  - FSM state typedef
- One sub-module: vend_coin_fifo (sync FIFO, FIFO_DEPTH x 2 bits, push/pop/full/empty, simultaneous push and pop allowed when full or empty as appropriate).

Test Plan:
- Reset, then A offers 10 then 5 -> ack_a twice; core_en pulses with core_in 10 then 01; motor_start once; on motor_done stock 10 -> 9; change_req never asserts.
- A and B request together every cycle with coin 01 -> acks alternate A, B, A; the third coin triggers a vend; no acks during DISPENSE/CHANGE.
- Coins 10, 10 -> vend; after motor_done, change_req = 1 with change_amt = 01 until change_done.
- One 5 rs coin then idle -> exactly TIMEOUT_CYC idle cycles later core_en = 1 with core_in = 00; change_amt = 01; credit cleared.
- Stock 1: vend, then a new coin -> sold_out = 1, coin acked with coin_reject, core_en stays 0. Restock 5 -> stock 5, sold_out = 0.
- rst asserted while change_req = 1 -> change_req, motor_start, core_en = 0 at once; stock = INIT_STOCK; busy = 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin codes, price and FSM state encoding for the vending front-end.
package vend_pkg;
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Price expressed in 5 rs units; a coin code's numeric value is its unit count.
    localparam int PRICE_UNITS = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_FEED     = 2'd1;
    localparam state_t ST_DISPENSE = 2'd2;
    localparam state_t ST_CHANGE   = 2'd3;
endpackage

// File: rtl/vend_coin_fifo.sv
// Small synchronous coin FIFO; push while full is accepted only alongside a pop.
module vend_coin_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wr_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
endmodule

// File: rtl/vend_coin_scheduler.sv
// Coin arbitration, credit tracking, timeout refund and dispense/change sequencing
// in front of the single-product vending core.
module vend_coin_scheduler
    import vend_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int STOCK_W     = 6,
    parameter int INIT_STOCK  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_a,
    input  logic [1:0]         coin_a,
    output logic               ack_a,
    input  logic               req_b,
    input  logic [1:0]         coin_b,
    output logic               ack_b,
    output logic               coin_reject,
    output logic               core_en,
    output logic [1:0]         core_in,
    output logic               motor_start,
    input  logic               motor_done,
    output logic               change_req,
    output logic [1:0]         change_amt,
    input  logic               change_done,
    input  logic               restock,
    input  logic [STOCK_W-1:0] restock_qty,
    output logic [STOCK_W-1:0] stock,
    output logic               sold_out,
    output logic               busy
);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW   = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    PRICE    = 3'(PRICE_UNITS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_credit;
    logic               r_rr;          // 1: slot B has priority on a tie
    logic               r_owed;
    logic [1:0]         r_change_amt;
    logic               r_motor_start;
    logic [STOCK_W-1:0] r_stock;
    logic [TW-1:0]      r_tmo_cnt;

    logic               w_open;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [CNTW-1:0]    w_count;
    logic [CNTW-1:0]    w_cnt_nxt;
    logic [1:0]         w_head;
    logic [1:0]         w_push_coin;
    logic               w_can_grant;
    logic               w_gnt_a;
    logic               w_gnt_b;
    logic               w_sold_out;
    logic [2:0]         w_sum;
    logic               w_vend;
    logic               w_tmo_arm;
    logic               w_cancel;
    logic [STOCK_W:0]   w_stock_sum;
    logic [STOCK_W:0]   w_stock_adj;
    logic               w_dec;
    logic [STOCK_W-1:0] w_stock_nxt;

    assign w_open      = (r_state == ST_IDLE) || (r_state == ST_FEED);
    assign w_sold_out  = (r_stock == '0);
    assign w_pop       = w_open && !w_empty;
    assign w_can_grant = w_open && !w_full;
    assign w_gnt_a     = w_can_grant && req_a && (!req_b || !r_rr);
    assign w_gnt_b     = w_can_grant && req_b && (!req_a || r_rr);
    assign w_push      = (w_gnt_a || w_gnt_b) && !w_sold_out;
    assign w_push_coin = w_gnt_a ? coin_a : coin_b;
    assign w_cnt_nxt   = w_count + CNTW'(w_push) - CNTW'(w_pop);

    vend_coin_fifo #(.DEPTH(FIFO_DEPTH), .W(2)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data (w_push_coin),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // Coin code value doubles as its 5 rs unit count, so credit math is plain addition.
    assign w_sum     = {1'b0, r_credit} + {1'b0, w_head};
    assign w_vend    = w_pop && (w_sum >= PRICE);
    assign w_tmo_arm = (r_state == ST_IDLE) && (r_credit != 2'd0) && w_empty;
    assign w_cancel  = w_tmo_arm && (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_FEED: begin
                if (w_vend)                 w_state_nxt = ST_DISPENSE;
                else if (w_cancel)          w_state_nxt = ST_CHANGE;
                else if (w_cnt_nxt != '0)   w_state_nxt = ST_FEED;
                else                        w_state_nxt = ST_IDLE;
            end
            ST_DISPENSE: if (motor_done)  w_state_nxt = r_owed ? ST_CHANGE : ST_IDLE;
            ST_CHANGE:   if (change_done) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Restock and dispense in one cycle: add first, then take one, then clamp.
    assign w_stock_sum = {1'b0, r_stock} + ({1'b0, restock_qty} & {(STOCK_W+1){restock}});
    assign w_dec       = (r_state == ST_DISPENSE) && motor_done && (w_stock_sum != '0);
    assign w_stock_adj = w_stock_sum - {{STOCK_W{1'b0}}, w_dec};
    assign w_stock_nxt = w_stock_adj[STOCK_W] ? '1 : w_stock_adj[STOCK_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_credit      <= 2'd0;
            r_rr          <= 1'b0;
            r_owed        <= 1'b0;
            r_change_amt  <= COIN_NONE;
            r_motor_start <= 1'b0;
            r_stock       <= STOCK_W'(INIT_STOCK);
            r_tmo_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_motor_start <= (w_state_nxt == ST_DISPENSE) && (r_state != ST_DISPENSE);
            r_stock       <= w_stock_nxt;
            if (w_gnt_a || w_gnt_b) r_rr <= w_gnt_a;
            if (w_pop) begin
                if (w_vend) begin
                    r_credit <= 2'd0;
                    r_owed   <= (w_sum != PRICE);
                    if (w_sum != PRICE) r_change_amt <= COIN_5;
                end else begin
                    r_credit <= w_sum[1:0];
                end
            end else if (w_cancel) begin
                r_change_amt <= r_credit;
                r_credit     <= 2'd0;
            end
            if (w_tmo_arm && !w_cancel) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                        r_tmo_cnt <= '0;
        end
    end

    assign ack_a       = w_gnt_a;
    assign ack_b       = w_gnt_b;
    assign coin_reject = (w_gnt_a || w_gnt_b) && w_sold_out;
    assign core_en     = w_pop || w_cancel;
    assign core_in     = w_pop ? w_head : COIN_NONE;
    assign motor_start = r_motor_start;
    assign change_req  = (r_state == ST_CHANGE);
    assign change_amt  = change_req ? r_change_amt : COIN_NONE;
    assign stock       = r_stock;
    assign sold_out    = w_sold_out;
    assign busy        = (r_state != ST_IDLE) || (r_credit != 2'd0);
endmodule
